// File: rtl/aes_256_stream_rx.sv
// Result-side valid/ready adapter around a fixed-latency AES-256 pipeline core.
// Define AES_RX_IDLE_ZERO_EN to drive the core inputs to zero on cycles without an accept.
module aes_256_stream_rx #(
    parameter int LATENCY = 121,
    parameter int DEPTH   = 128,
    parameter int IDW     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [127:0]               in_state,
    input  logic [255:0]               in_key,
    input  logic [IDW-1:0]             in_id,
    output logic [127:0]               core_state,
    output logic [255:0]               core_key,
    input  logic [127:0]               core_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [127:0]               out_data,
    output logic [IDW-1:0]             out_id,
    output logic [$clog2(DEPTH):0]     credits
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 128 + IDW;

    logic              accept;
    logic              pop;
    logic              fifo_wr;
    logic              fifo_full;
    logic [CW-1:0]     credits_reg;
    logic [CW-1:0]     count_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [EW-1:0]     fifo_mem [DEPTH];
    logic [EW-1:0]     head;
    logic              tag_valid_reg [0:LATENCY];
    logic [IDW-1:0]    tag_id_reg    [0:LATENCY];

    assign in_ready  = (credits_reg != '0);
    assign credits   = credits_reg;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (count_reg == CW'(DEPTH));
    assign fifo_wr   = tag_valid_reg[LATENCY];
    assign head      = fifo_mem[rd_ptr_reg];
    assign out_data  = out_valid ? head[EW-1:IDW] : '0;
    assign out_id    = out_valid ? head[IDW-1:0]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_reg <= CW'(DEPTH);
        end else begin
            case ({accept, pop})
                2'b10:   credits_reg <= credits_reg - CW'(1);
                2'b01:   credits_reg <= credits_reg + CW'(1);
                default: credits_reg <= credits_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_state <= '0;
            core_key   <= '0;
        end else if (accept) begin
            core_state <= in_state;
            core_key   <= in_key;
        end else begin
`ifdef AES_RX_IDLE_ZERO_EN
            core_state <= '0;
            core_key   <= '0;
`else
            core_state <= core_state;
            core_key   <= core_key;
`endif
        end
    end

    // Stage 0 lines up with core_state/core_key; LATENCY further stages
    // bring the tag level with the matching core_out cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg[0] <= 1'b0;
        end else begin
            tag_valid_reg[0] <= accept;
        end
    end

    always_ff @(posedge clk) begin
        tag_id_reg[0] <= in_id;
    end

    generate
        for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_valid_reg[gi] <= 1'b0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                end
            end

            always_ff @(posedge clk) begin
                tag_id_reg[gi] <= tag_id_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= {core_out, tag_id_reg[LATENCY]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Credits bound occupancy, so this can only fire on a logic error.
    always_ff @(posedge clk) begin
        if (rst_n && fifo_wr) begin
            assert (!fifo_full)
            else $error("aes_256_stream_rx: write to full result FIFO");
        end
    end

endmodule

// File: tb/tb_aes_256_stream_rx.sv
// Directed bench for aes_256_stream_rx using a stand-in core: a LATENCY-deep
// pipeline of state ^ key_hi ^ key_lo, so expected ciphertexts are easy to derive.
module tb_aes_256_stream_rx;
    localparam int LAT = 121;
    localparam int DEP = 128;
    localparam int IDW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_state = '0;
    logic [255:0]   in_key = '0;
    logic [IDW-1:0] in_id = '0;
    logic [127:0]   core_state;
    logic [255:0]   core_key;
    logic [127:0]   core_out;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   out_data;
    logic [IDW-1:0] out_id;
    logic [7:0]     credits;

    int checks = 0;
    int passes = 0;
    int n_acc  = 0;
    int n_out  = 0;
    logic [127+IDW:0] sb [$];
    logic [127:0] core_pipe [LAT];

    always #5 clk = ~clk;

    aes_256_stream_rx #(.LATENCY(LAT), .DEPTH(DEP), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_key     (in_key),
        .in_id      (in_id),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .credits    (credits)
    );

    function automatic logic [127:0] fake_core(input logic [127:0] s, input logic [255:0] k);
        return s ^ k[255:128] ^ k[127:0];
    endfunction

    always_ff @(posedge clk) begin
        core_pipe[0] <= fake_core(core_state, core_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LAT-1];

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rand_beat(input int id);
        in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key   = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
        in_id    = IDW'(id);
    endtask

    // One clock: score any pop, record any accept, then advance to 1 ns after the edge.
    task automatic step();
        logic [127+IDW:0] exp;
        bit acc;
        bit pp;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        if (pp) begin
            check("pop_expected", 384'(sb.size() != 0), 384'(1));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                $display("result id=%02h data=%032h", out_id, out_data);
                check("out_data", 384'(out_data), 384'(exp[127+IDW:IDW]));
                check("out_id", 384'(out_id), 384'(exp[IDW-1:0]));
                n_out++;
            end
        end
        if (acc) begin
            sb.push_back({fake_core(in_state, in_key), in_id});
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int acc0;
        int out0;
        bit dropped;
        bit seen;
        logic [127:0] vec_state;

        // Reset for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 384'(in_ready), 384'(1));
        check("rst_credits", 384'(credits), 384'(DEP));
        check("rst_out_valid", 384'(out_valid), 384'(0));
        check("rst_out_data", 384'(out_data), 384'(0));
        check("rst_out_id", 384'(out_id), 384'(0));
        check("rst_core_key", 384'(core_key), 384'(0));
        check("rst_core_state", 384'(core_state), 384'(0));
        rst_n = 1'b1;
        step();

        // Single beat with latency measurement
        vec_state = 128'h00112233445566778899aabbccddeeff;
        in_state  = vec_state;
        in_key    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        in_id     = 8'h5A;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_credits", 384'(credits), 384'(DEP - 1));
        check("single_core_state", 384'(core_state), 384'(vec_state));
        step();
`ifdef AES_RX_IDLE_ZERO_EN
        check("idle_core_state", 384'(core_state), 384'(0));
`else
        check("idle_core_state", 384'(core_state), 384'(vec_state));
`endif
        n = 2;
        while (!out_valid && n < 300) begin
            step();
            n++;
        end
        check("single_latency", 384'(n), 384'(LAT + 2));
        check("single_data", 384'(out_data), 384'(128'h10013223544576679889baabdccdfeef));
        check("single_id", 384'(out_id), 384'(8'h5A));
        out_ready = 1'b1;
        step();
        check("single_drained", 384'(out_valid), 384'(0));
        check("single_credits_back", 384'(credits), 384'(DEP));

        // Back-to-back streaming with open output
        dropped = 1'b0;
        out0 = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_beat(i);
            if (!in_ready) dropped = 1'b1;
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("stream_ready_held", 384'(dropped), 384'(0));
        check("stream_count", 384'(n_out - out0), 384'(200));

        // Backpressure until credits run out
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 300; i++) begin
            rand_beat(i);
            step();
        end
        in_valid = 1'b0;
        check("bp_accepts", 384'(n_acc - acc0), 384'(DEP));
        check("bp_in_ready", 384'(in_ready), 384'(0));
        check("bp_credits", 384'(credits), 384'(0));
        check("bp_out_valid", 384'(out_valid), 384'(1));
        out_ready = 1'b1;
        step();
        check("bp_ready_restored", 384'(in_ready), 384'(1));
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("bp_drain_count", 384'(n_out - out0), 384'(DEP));
        check("bp_credits_full", 384'(credits), 384'(DEP));

        // Accept and pop together with one credit left
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEP - 1; i++) begin
            rand_beat(i);
            step();
        end
        in_valid = 1'b0;
        check("edge_credits_one", 384'(credits), 384'(1));
        repeat (LAT + 5) step();
        rand_beat(8'hEE);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("edge_credits_hold", 384'(credits), 384'(1));
        check("edge_in_ready_hold", 384'(in_ready), 384'(1));
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("edge_drained", 384'(sb.size()), 384'(0));

        // Reset with beats in flight
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_beat(i);
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("arst_credits", 384'(credits), 384'(DEP));
        check("arst_out_valid", 384'(out_valid), 384'(0));
        check("arst_core_state", 384'(core_state), 384'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("post_rst_no_valid", 384'(seen), 384'(0));
        check("post_rst_credits", 384'(credits), 384'(DEP));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
